// File: rtl/pkt_size_meter.sv
// Packet size meter: extracts the flow number from each sop word, counts packet bytes and
// emits one {flow, size, enable} report per good packet to the per-flow statistics accumulator.
module pkt_size_meter #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned A_WIDTH  = 10,
    parameter int unsigned FLOW_LSB = 0,
    parameter int unsigned EMPTY_W  = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               val_i,
    input  logic               sop_i,
    input  logic               eop_i,
    input  logic [EMPTY_W-1:0] empty_i,
    input  logic               err_i,
    output logic [A_WIDTH-1:0] rx_flow_num_o,
    output logic [15:0]        pkt_size_o,
    output logic               pkt_size_ena_o,
    output logic [15:0]        drop_err_cnt_o,
    output logic [15:0]        drop_fmt_cnt_o
);

    typedef enum logic [0:0] {StIdle, StInPkt} state_e;

    localparam logic [16:0] Bytes = 17'(DATA_W / 8);

    state_e             state_q, state_d;
    logic [16:0]        cnt_q, cnt_d;
    logic [A_WIDTH-1:0] flow_q, flow_d;
    logic [A_WIDTH-1:0] out_flow_q, out_flow_d;
    logic [15:0]        out_size_q, out_size_d;
    logic               ena_q, ena_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [15:0]        fmt_cnt_q, fmt_cnt_d;

    logic               rpt, fmt_inc, err_inc;
    logic [A_WIDTH-1:0] rpt_flow;
    logic [15:0]        rpt_size;
    logic [A_WIDTH-1:0] sop_flow;
    logic [16:0]        empty_ext;
    logic [16:0]        eop_bytes;
    logic               unused_data;

    // Sums never exceed 17 bits, so bit 16 alone flags an overflow past 0xFFFF.
    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    assign sop_flow    = data_i[FLOW_LSB +: A_WIDTH];
    assign unused_data = ^data_i;
    assign empty_ext   = 17'(empty_i);
    // An oversized empty still leaves one valid byte in the eop beat.
    assign eop_bytes   = (empty_ext >= Bytes) ? 17'd1 : Bytes - empty_ext;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flow_d   = flow_q;
        rpt      = 1'b0;
        rpt_flow = flow_q;
        rpt_size = sat16(cnt_q + eop_bytes);
        fmt_inc  = 1'b0;
        if (val_i) begin
            if (sop_i) begin
                // A sop inside an open packet closes it as a format violation.
                fmt_inc = (state_q == StInPkt);
                if (eop_i) begin
                    rpt      = 1'b1;
                    rpt_flow = sop_flow;
                    rpt_size = sat16(eop_bytes);
                    state_d  = StIdle;
                    cnt_d    = '0;
                end else begin
                    flow_d  = sop_flow;
                    cnt_d   = Bytes;
                    state_d = StInPkt;
                end
            end else if (state_q == StIdle) begin
                fmt_inc = 1'b1;
            end else if (eop_i) begin
                rpt     = 1'b1;
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = {1'b0, sat16(cnt_q + Bytes)};
            end
        end
        ena_d      = rpt & ~err_i;
        err_inc    = rpt & err_i;
        out_flow_d = ena_d ? rpt_flow : out_flow_q;
        out_size_d = ena_d ? rpt_size : out_size_q;
        err_cnt_d  = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        fmt_cnt_d  = (fmt_inc && fmt_cnt_q != 16'hFFFF) ? fmt_cnt_q + 16'd1 : fmt_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            flow_q     <= '0;
            out_flow_q <= '0;
            out_size_q <= '0;
            ena_q      <= 1'b0;
            err_cnt_q  <= '0;
            fmt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flow_q     <= flow_d;
            out_flow_q <= out_flow_d;
            out_size_q <= out_size_d;
            ena_q      <= ena_d;
            err_cnt_q  <= err_cnt_d;
            fmt_cnt_q  <= fmt_cnt_d;
        end
    end

    assign rx_flow_num_o  = out_flow_q;
    assign pkt_size_o     = out_size_q;
    assign pkt_size_ena_o = ena_q;
    assign drop_err_cnt_o = err_cnt_q;
    assign drop_fmt_cnt_o = fmt_cnt_q;

endmodule

// File: doc/pkt_size_meter.md
Name: pkt_size_meter

Overview:
- Upstream feeder for the per-flow statistics accumulator.
- Watches a non-backpressured packet stream and extracts the flow number from the first word of each packet.
- Counts packet bytes, then emits one {flow number, packet size, enable} pulse per good packet.
- Its outputs connect directly to the accumulator's rx_flow_num_i / pkt_size_i / pkt_size_ena_i.

Parameters:
- DATA_W, 64, stream data width in bits; a power of 2, at least 16.
- A_WIDTH, 10, flow number width; must match the accumulator's A_WIDTH.
- FLOW_LSB, 0, LSB position of the flow field in the first (sop) word; FLOW_LSB + A_WIDTH <= DATA_W.
- EMPTY_W, 3, width of empty_i; equals log2(DATA_W/8).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- data_i  in  DATA_W  stream data.
- val_i  in  1  beat valid. The block is always ready; there is no backpressure.
- sop_i  in  1  first beat of packet; qualified by val_i.
- eop_i  in  1  last beat of packet; qualified by val_i.
- empty_i  in  EMPTY_W  count of unused bytes in the eop beat; ignored on non-eop beats.
- err_i  in  1  packet error flag; sampled on the eop beat.
- rx_flow_num_o  out  A_WIDTH  flow number of the reported packet.
- pkt_size_o  out  16  packet length in bytes, saturated.
- pkt_size_ena_o  out  1  one-cycle pulse; rx_flow_num_o and pkt_size_o are valid while it is high.
- drop_err_cnt_o  out  16  packets dropped because err_i was set; saturates at 0xFFFF.
- drop_fmt_cnt_o  out  16  format violations; saturates at 0xFFFF.

Behaviour:
- Reset: asynchronous assertion, synchronous release. While rst_n_i is low:
  - all outputs are 0 and pkt_size_ena_o is 0;
  - the FSM is in IDLE and the byte counter is 0.
- Reset mid-packet discards that packet with no report and no count.
- BYTES = DATA_W/8.
- FSM states: IDLE and IN_PKT.
- IDLE:
  - val & sop & eop: single-beat packet, size = BYTES - empty_i; report; stay in IDLE.
  - val & sop & !eop: latch flow = data_i[FLOW_LSB +: A_WIDTH], cnt = BYTES, go to IN_PKT.
  - val & !sop (orphan beat): ignore data; drop_fmt_cnt_o += 1; stay in IDLE. An orphan beat that also has eop counts once.
- IN_PKT:
  - val & !sop & !eop: cnt += BYTES (saturating at 0xFFFF).
  - val & !sop & eop: size = cnt + BYTES - empty_i (saturating); report; go to IDLE.
  - val & sop: missing eop. The open packet is discarded (no report) and drop_fmt_cnt_o += 1. The sop beat then starts a new packet exactly as in IDLE, including the sop & eop single-beat case.
  - !val: hold.
- Report:
  - If err_i = 0 on the eop beat, the next cycle has pkt_size_ena_o = 1 with rx_flow_num_o = latched flow and pkt_size_o = computed size.
  - If err_i = 1, there is no pulse and drop_err_cnt_o += 1.
  - Latency is exactly 1 cycle from the eop beat to pkt_size_ena_o.
- rx_flow_num_o and pkt_size_o hold their last reported value when pkt_size_ena_o is 0.
- Back-to-back single-beat packets produce pkt_size_ena_o high on consecutive cycles. This is legal: the accumulator merges same-flow back-to-back writes.
- Arithmetic:
  - The counter is 17 bits internally; any sum above 0xFFFF clamps to 0xFFFF.
  - empty_i values >= BYTES are treated as BYTES - 1, so every eop beat contributes at least 1 byte.
- The two drop counters update in the cycle after the causing beat. They never wrap. Both may increment in the same cycle. Example: in IN_PKT, a sop & eop & err beat closes an unterminated packet (+1 fmt) and is itself dropped (+1 err).

Test Plan:
- Single-beat packet: sop/eop/val, empty_i=3, data_i[9:0]=0x155, DATA_W=64 -> one cycle later pkt_size_ena_o=1, rx_flow_num_o=0x155, pkt_size_o=5; both drop counters stay 0.
- 4-beat packet, flow 0x02A, eop empty_i=0 -> pkt_size_o=32 exactly 1 cycle after eop; val_i gaps inserted mid-packet do not change the result.
- 10000-beat packet -> pkt_size_o=0xFFFF (saturated).
- Error and orphan handling:
  - 3-beat packet with err_i=1 on eop -> no pulse, drop_err_cnt_o=1.
  - Orphan beat (val without sop) in IDLE -> drop_fmt_cnt_o=1, no pulse.
- Missing eop: sop (flow 5), one middle beat, then sop & eop (flow 7, empty 0) -> a single pulse with flow 7, size 8; drop_fmt_cnt_o=1.
- Back-to-back single-beat packets of flows 1, 1, 2 on consecutive cycles -> three consecutive pulses with the matching flows.
- Reset mid-packet: assert rst_n_i low during beat 2 -> outputs 0 immediately. After release, a new sop packet reports correctly, with no stale size carried over.
